apb_master_q: RTL and testbench

Queued, multi-slave APB4 master: accepts read/write commands through a valid/ready port into a command FIFO, runs one APB transfer per command toward one of NSLV slaves, and returns a response for every command on a valid/ready port. It is the next-generation master in the APB subsystem. Over a single-slave, unbuffered master it adds:

- command buffering
- PSTRB
- PSLVERR capture
- address-decoded PSEL
- response back-pressure
- an optional transfer timeout

---
 rtl/apb_master_q.sv | 177 +++++++++++++++++
 tb/tb_apb_master_q.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_q.sv
// apb_master_q: queued multi-slave APB4 master (command FIFO, single-entry response slot).
// Define APB_MST_TIMEOUT_EN to abort ACCESS phases that wait longer than TIMEOUT cycles.
module apb_master_q #(
   parameter int unsigned DATA_WD    = 32,
   parameter int unsigned ADDR_WD    = 16,
   parameter int unsigned NSLV       = 4,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_vld,
   output logic                   cmd_rdy,
   input  logic                   cmd_write,
   input  logic [ADDR_WD-1:0]     cmd_addr,
   input  logic [DATA_WD-1:0]     cmd_wdata,
   input  logic [DATA_WD/8-1:0]   cmd_strb,
   output logic                   rsp_vld,
   input  logic                   rsp_rdy,
   output logic                   rsp_write,
   output logic [DATA_WD-1:0]     rsp_rdata,
   output logic                   rsp_err,
   output logic [NSLV-1:0]        psel,
   output logic                   penable,
   output logic                   pwrite,
   output logic [ADDR_WD-1:0]     paddr,
   output logic [DATA_WD-1:0]     pwdata,
   output logic [DATA_WD/8-1:0]   pstrb,
   input  logic [DATA_WD-1:0]     prdata,
   input  logic                   pready,
   input  logic                   pslverr
);
   localparam int unsigned SEL_WD  = $clog2(NSLV);
   localparam int unsigned STRB_WD = DATA_WD / 8;
   localparam int unsigned PTR_WD  = $clog2(FIFO_DEPTH);
   localparam logic [(1 << SEL_WD)-1:0] SLV_MASK = {(1 << SEL_WD){1'b1}} >> ((1 << SEL_WD) - NSLV);

   // Reject parameter sets the datapath cannot represent.
   if (TIMEOUT < 1 || NSLV < 2 || NSLV > 16 || (DATA_WD % 8) != 0 ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
      $error("apb_master_q: illegal parameter set");
   end

   typedef struct packed {
      logic               write;
      logic [ADDR_WD-1:0] addr;
      logic [DATA_WD-1:0] wdata;
      logic [STRB_WD-1:0] strb;
   } cmd_t;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DERR} state_t;

   cmd_t              r_mem [FIFO_DEPTH];
   logic [PTR_WD:0]   r_wr_ptr;
   logic [PTR_WD:0]   r_rd_ptr;
   state_t            r_state;
   logic              r_cmd_write;
   logic              w_empty;
   logic              w_full;
   logic              w_push;
   logic              w_pop;
   cmd_t              w_head;
   logic [SEL_WD-1:0] w_idx;
   logic              w_idx_ok;

`ifdef APB_MST_TIMEOUT_EN
   localparam int unsigned CNT_WD = $clog2(TIMEOUT + 1);
   logic [CNT_WD-1:0] r_to_cnt;
`endif

   assign w_empty  = (r_wr_ptr == r_rd_ptr);
   assign w_full   = (r_wr_ptr[PTR_WD] != r_rd_ptr[PTR_WD]) &&
                     (r_wr_ptr[PTR_WD-1:0] == r_rd_ptr[PTR_WD-1:0]);
   assign cmd_rdy  = !w_full;
   assign w_push   = cmd_vld && !w_full;
   assign w_pop    = (r_state == S_IDLE) && !w_empty && (!rsp_vld || rsp_rdy);
   assign w_head   = r_mem[r_rd_ptr[PTR_WD-1:0]];
   assign w_idx    = w_head.addr[ADDR_WD-1 -: SEL_WD];
   assign w_idx_ok = SLV_MASK[w_idx];

   // Command storage; contents need no reset because the pointers qualify them.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[PTR_WD-1:0]] <= '{write: cmd_write, addr: cmd_addr,
                                          wdata: cmd_wdata, strb: cmd_strb};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_WD+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_WD+1)'(1);
      end
   end

   // Transfer FSM with registered APB and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cmd_write <= 1'b0;
         psel        <= '0;
         penable     <= 1'b0;
         pwrite      <= 1'b0;
         paddr       <= '0;
         pwdata      <= '0;
         pstrb       <= '0;
         rsp_vld     <= 1'b0;
         rsp_write   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
`ifdef APB_MST_TIMEOUT_EN
         r_to_cnt    <= '0;
`endif
      end else begin
         if (rsp_vld && rsp_rdy) rsp_vld <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_cmd_write <= w_head.write;
                  if (w_idx_ok) begin
                     pwrite  <= w_head.write;
                     paddr   <= w_head.addr;
                     pwdata  <= w_head.wdata;
                     pstrb   <= w_head.write ? w_head.strb : '0;
                     psel    <= NSLV'(1) << w_idx;
                     r_state <= S_SETUP;
                  end else begin
                     r_state <= S_DERR;
                  end
               end
            end
            S_SETUP: begin
               penable <= 1'b1;
               r_state <= S_ACCESS;
`ifdef APB_MST_TIMEOUT_EN
               r_to_cnt <= '0;
`endif
            end
            S_ACCESS: begin
               if (pready) begin
                  psel      <= '0;
                  penable   <= 1'b0;
                  rsp_vld   <= 1'b1;
                  rsp_write <= r_cmd_write;
                  rsp_err   <= pslverr;
                  rsp_rdata <= (!r_cmd_write && !pslverr) ? prdata : '0;
                  r_state   <= S_IDLE;
               end
`ifdef APB_MST_TIMEOUT_EN
               else if (r_to_cnt == CNT_WD'(TIMEOUT - 1)) begin
                  psel      <= '0;
                  penable   <= 1'b0;
                  rsp_vld   <= 1'b1;
                  rsp_write <= r_cmd_write;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  r_state   <= S_IDLE;
               end else begin
                  r_to_cnt <= r_to_cnt + CNT_WD'(1);
               end
`endif
            end
            S_DERR: begin
               rsp_vld   <= 1'b1;
               rsp_write <= r_cmd_write;
               rsp_err   <= 1'b1;
               rsp_rdata <= '0;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_master_q.sv
// Directed self-checking bench for apb_master_q: a 4-slave instance and a 3-slave instance
// (decode error). Timeout expectations follow APB_MST_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_apb_master_q;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        cmd_vld, cmd_rdy, cmd_write;
   logic [15:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_vld, rsp_rdy, rsp_write, rsp_err;
   logic [31:0] rsp_rdata;
   logic [3:0]  psel;
   logic        penable, pwrite;
   logic [15:0] paddr;
   logic [31:0] pwdata, prdata, prdata_drv;
   logic [3:0]  pstrb;
   logic        pready, pslverr, use_model;

   assign prdata = use_model ? {16'h5A5A, paddr} : prdata_drv;

   logic        d1_cmd_vld, d1_cmd_rdy, d1_cmd_write;
   logic [15:0] d1_cmd_addr;
   logic [31:0] d1_cmd_wdata;
   logic [3:0]  d1_cmd_strb;
   logic        d1_rsp_vld, d1_rsp_rdy, d1_rsp_write, d1_rsp_err;
   logic [31:0] d1_rsp_rdata;
   logic [2:0]  d1_psel;
   logic        d1_penable, d1_pwrite;
   logic [15:0] d1_paddr;
   logic [31:0] d1_pwdata, d1_prdata;
   logic [3:0]  d1_pstrb;
   logic        d1_pready, d1_pslverr;

   apb_master_q #(.DATA_WD(32), .ADDR_WD(16), .NSLV(4), .FIFO_DEPTH(4), .TIMEOUT(8)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr));

   apb_master_q #(.DATA_WD(32), .ADDR_WD(16), .NSLV(3), .FIFO_DEPTH(4), .TIMEOUT(8)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .cmd_vld(d1_cmd_vld), .cmd_rdy(d1_cmd_rdy), .cmd_write(d1_cmd_write),
      .cmd_addr(d1_cmd_addr), .cmd_wdata(d1_cmd_wdata), .cmd_strb(d1_cmd_strb),
      .rsp_vld(d1_rsp_vld), .rsp_rdy(d1_rsp_rdy), .rsp_write(d1_rsp_write),
      .rsp_rdata(d1_rsp_rdata), .rsp_err(d1_rsp_err),
      .psel(d1_psel), .penable(d1_penable), .pwrite(d1_pwrite), .paddr(d1_paddr),
      .pwdata(d1_pwdata), .pstrb(d1_pstrb), .prdata(d1_prdata), .pready(d1_pready),
      .pslverr(d1_pslverr));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one command and wait (bounded) for the handshake edge.
   task automatic push(input logic wr, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] s);
      logic acc;
      int   n;
      cmd_vld = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 20) begin
         acc = cmd_rdy;
         step();
         n++;
      end
      cmd_vld = 1'b0;
      chk("push_accept", 32'(acc), 32'd1);
   endtask

   logic [15:0] bp_addr [6] = '{16'h0100, 16'h4200, 16'h8300, 16'hC400, 16'h0500, 16'h4600};
   logic        bp_wr   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      int   n_rsp;
      rst_n = 1'b0;
      cmd_vld = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
      rsp_rdy = 1; pready = 1; pslverr = 0; prdata_drv = '0; use_model = 0;
      d1_cmd_vld = 0; d1_cmd_write = 0; d1_cmd_addr = '0; d1_cmd_wdata = '0; d1_cmd_strb = '0;
      d1_rsp_rdy = 1; d1_pready = 1; d1_pslverr = 0; d1_prdata = 32'h0BADF00D;
      step(); step();
      chk("rst_psel", 32'(psel), 0);
      chk("rst_penable", 32'(penable), 0);
      chk("rst_rsp_vld", 32'(rsp_vld), 0);
      chk("rst_cmd_rdy", 32'(cmd_rdy), 1);
      chk("rst_paddr", 32'(paddr), 0);
      chk("rst_pstrb", 32'(pstrb), 0);
      rst_n = 1'b1;
      step(); step();

      // Write to slave 1, zero wait states.
      push(1'b1, 16'h4010, 32'hA5A50001, 4'hF);
      chk("wr_idle_psel", 32'(psel), 0);
      step();
      chk("wr_setup_psel", 32'(psel), 32'b0010);
      chk("wr_setup_penable", 32'(penable), 0);
      chk("wr_pwrite", 32'(pwrite), 1);
      chk("wr_paddr", 32'(paddr), 32'h4010);
      chk("wr_pwdata", pwdata, 32'hA5A50001);
      chk("wr_pstrb", 32'(pstrb), 32'hF);
      step();
      chk("wr_access_penable", 32'(penable), 1);
      chk("wr_access_psel", 32'(psel), 32'b0010);
      step();
      chk("wr_rsp_vld", 32'(rsp_vld), 1);
      chk("wr_rsp_write", 32'(rsp_write), 1);
      chk("wr_rsp_err", 32'(rsp_err), 0);
      chk("wr_rsp_rdata", rsp_rdata, 0);
      chk("wr_done_psel", 32'(psel), 0);
      step();
      chk("wr_rsp_consumed", 32'(rsp_vld), 0);

      // Read from slave 3 with three wait states.
      pready = 1'b0;
      push(1'b0, 16'hC004, 32'h11112222, 4'hF);
      step();
      chk("rd_psel", 32'(psel), 32'b1000);
      chk("rd_pstrb", 32'(pstrb), 0);
      chk("rd_pwrite", 32'(pwrite), 0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("rd_penable_%0d", i), 32'(penable), 1);
      end
      chk("rd_wait_rsp_vld", 32'(rsp_vld), 0);
      pready = 1'b1; prdata_drv = 32'hDEADBEEF;
      step();
      chk("rd_rsp_vld", 32'(rsp_vld), 1);
      chk("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("rd_rsp_write", 32'(rsp_write), 0);
      chk("rd_penable_off", 32'(penable), 0);

      // Slave error on a read.
      pslverr = 1'b1; prdata_drv = 32'h12345678;
      push(1'b0, 16'h0008, 32'h0, 4'hF);
      step();
      chk("err_psel", 32'(psel), 32'b0001);
      step(); step();
      chk("err_rsp_vld", 32'(rsp_vld), 1);
      chk("err_rsp_err", 32'(rsp_err), 1);
      chk("err_rsp_rdata", rsp_rdata, 0);
      pslverr = 1'b0;
      step(); step();

      // Response back-pressure: one pending response plus a full FIFO.
      use_model = 1'b1; rsp_rdy = 1'b0;
      for (int i = 0; i < 5; i++) push(bp_wr[i], bp_addr[i], 32'h100 + 32'(i), 4'h5);
      chk("bp_cmd_rdy", 32'(cmd_rdy), 0);
      chk("bp_rsp_vld", 32'(rsp_vld), 1);
      chk("bp_first_rdata", rsp_rdata, 32'h5A5A0100);
      cmd_vld = 1'b1; cmd_write = bp_wr[5]; cmd_addr = bp_addr[5]; cmd_wdata = 32'h105;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_stall_psel", 32'(psel), 0);
         chk("bp_stall_cmd_rdy", 32'(cmd_rdy), 0);
         chk("bp_stall_rdata", rsp_rdata, 32'h5A5A0100);
      end
      rsp_rdy = 1'b1;
      n_rsp = 0;
      for (int cyc = 0; cyc < 80 && n_rsp < 6; cyc++) begin
         if (rsp_vld) begin
            chk($sformatf("bp_write_%0d", n_rsp), 32'(rsp_write), 32'(bp_wr[n_rsp]));
            chk($sformatf("bp_rdata_%0d", n_rsp), rsp_rdata,
                bp_wr[n_rsp] ? 32'h0 : {16'h5A5A, bp_addr[n_rsp]});
            chk($sformatf("bp_err_%0d", n_rsp), 32'(rsp_err), 0);
            n_rsp++;
         end
         acc = cmd_vld && cmd_rdy;
         step();
         if (acc) cmd_vld = 1'b0;
      end
      chk("bp_rsp_count", 32'(n_rsp), 6);
      cmd_vld = 1'b0; use_model = 1'b0;
      step(); step();

      // Decode error on the 3-slave instance, then a legal slave 2 read.
      chk("dec_cmd_rdy", 32'(d1_cmd_rdy), 1);
      d1_cmd_vld = 1'b1; d1_cmd_write = 1'b0; d1_cmd_addr = 16'hC000;
      step();
      d1_cmd_vld = 1'b0;
      step();
      chk("dec_psel", 32'(d1_psel), 0);
      chk("dec_rsp_early", 32'(d1_rsp_vld), 0);
      step();
      chk("dec_rsp_vld", 32'(d1_rsp_vld), 1);
      chk("dec_rsp_err", 32'(d1_rsp_err), 1);
      chk("dec_rsp_rdata", d1_rsp_rdata, 0);
      chk("dec_psel_after", 32'(d1_psel), 0);
      d1_cmd_vld = 1'b1; d1_cmd_addr = 16'h8000;
      step();
      d1_cmd_vld = 1'b0;
      step();
      chk("dec_ok_psel", 32'(d1_psel), 32'b100);
      step(); step();
      chk("dec_ok_rsp_vld", 32'(d1_rsp_vld), 1);
      chk("dec_ok_rdata", d1_rsp_rdata, 32'h0BADF00D);
      chk("dec_ok_err", 32'(d1_rsp_err), 0);

      // Stalled slave (pready low) with a second command queued behind it.
      pready = 1'b0; prdata_drv = 32'h00000077;
      push(1'b0, 16'h4000, 32'h0, 4'hF);
      push(1'b1, 16'h8000, 32'hCAFE0002, 4'h3);
      chk("to_setup_psel", 32'(psel), 32'b0010);
      step();
      for (int i = 0; i < 7; i++) begin
         step();
         chk("to_wait_penable", 32'(penable), 1);
      end
`ifdef APB_MST_TIMEOUT_EN
      step();
      chk("to_abort_psel", 32'(psel), 0);
      chk("to_abort_penable", 32'(penable), 0);
      chk("to_abort_rsp_vld", 32'(rsp_vld), 1);
      chk("to_abort_rsp_err", 32'(rsp_err), 1);
      chk("to_abort_rdata", rsp_rdata, 0);
      pready = 1'b1;
`else
      for (int i = 0; i < 10; i++) begin
         step();
         chk("nto_penable", 32'(penable), 1);
         chk("nto_rsp_vld", 32'(rsp_vld), 0);
      end
      pready = 1'b1;
      step();
      chk("nto_rsp_vld_done", 32'(rsp_vld), 1);
      chk("nto_rsp_err", 32'(rsp_err), 0);
      chk("nto_rdata", rsp_rdata, 32'h00000077);
`endif
      step();
      chk("to_next_psel", 32'(psel), 32'b0100);
      chk("to_next_pstrb", 32'(pstrb), 32'h3);
      chk("to_next_rsp_vld", 32'(rsp_vld), 0);
      step(); step();
      chk("to_next_rsp", 32'(rsp_vld), 1);
      chk("to_next_err", 32'(rsp_err), 0);
      chk("to_next_write", 32'(rsp_write), 1);

      // Asynchronous reset in the middle of a transfer.
      pready = 1'b0;
      push(1'b1, 16'h4010, 32'h1, 4'hF);
      step();
      chk("mid_psel_before", 32'(psel), 32'b0010);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_psel", 32'(psel), 0);
      chk("mid_rst_penable", 32'(penable), 0);
      chk("mid_rst_cmd_rdy", 32'(cmd_rdy), 1);
      chk("mid_rst_rsp_vld", 32'(rsp_vld), 0);
      step();
      rst_n = 1'b1;
      pready = 1'b1;
      step(); step();
      chk("post_rst_psel", 32'(psel), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
